// File: rtl/grf_wb_pkg.sv
// Shared constants for the general register file and its write-register select path.
package grf_wb_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned PC_W     = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // Upstream write-register select encoding (rt / rd / $31).
   typedef enum logic [1:0] {
      WSEL_RT = 2'd0,
      WSEL_RD = 2'd1,
      WSEL_RA = 2'd2
   } wsel_e;

endpackage

// File: rtl/grf_trace.sv
// Registered write-back trace record and committed-write counter.
module grf_trace #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned PC_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              commit_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic              trace_valid_o,
   output logic [ADDR_W-1:0] trace_addr_o,
   output logic [DATA_W-1:0] trace_data_o,
   output logic [PC_W-1:0]   trace_pc_o,
   output logic [CNT_W-1:0]  wr_count_o
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Record captures only on commit; counter wraps naturally.
   always_comb begin
      valid_d = commit_i;
      addr_d  = addr_q;
      data_d  = data_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (commit_i) begin
         addr_d = addr_i;
         data_d = data_i;
         pc_d   = pc_i;
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign trace_valid_o = valid_q;
   assign trace_addr_o  = addr_q;
   assign trace_data_o  = data_q;
   assign trace_pc_o    = pc_q;
   assign wr_count_o    = cnt_q;

endmodule

// File: rtl/grf_wb.sv
// General register file: two bypassed combinational read ports, one write port,
// plus a registered write-back trace for the harness.
module grf_wb #(
   parameter int unsigned DATA_W   = grf_wb_pkg::DATA_W,
   parameter int unsigned ADDR_W   = grf_wb_pkg::ADDR_W,
   parameter int unsigned NUM_REGS = grf_wb_pkg::NUM_REGS,
   parameter int unsigned CNT_W    = grf_wb_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd,
   input  logic [31:0]       pc,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              trace_valid,
   output logic [ADDR_W-1:0] trace_addr,
   output logic [DATA_W-1:0] trace_data,
   output logic [31:0]       trace_pc,
   output logic [CNT_W-1:0]  wr_count
);
   import grf_wb_pkg::*;

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              commit_c;

   // Writes to $0 are dropped and never counted or traced.
   assign commit_c = we && (a3 != ZERO_ADDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (commit_c) begin
         regs_q[a3] <= wd;
      end
   end

   // Reads: $0 is hardwired zero, same-cycle write passes straight through.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (reset) begin
         if (a1 != ZERO_ADDR) begin
            rd1 = (commit_c && (a3 == a1)) ? wd : regs_q[a1];
         end
         if (a2 != ZERO_ADDR) begin
            rd2 = (commit_c && (a3 == a2)) ? wd : regs_q[a2];
         end
      end
   end

   grf_trace #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .PC_W   (32)
   ) u_trace (
      .clk           (clk),
      .reset         (reset),
      .commit_i      (commit_c),
      .addr_i        (a3),
      .data_i        (wd),
      .pc_i          (pc),
      .trace_valid_o (trace_valid),
      .trace_addr_o  (trace_addr),
      .trace_data_o  (trace_data),
      .trace_pc_o    (trace_pc),
      .wr_count_o    (wr_count)
   );

endmodule

// File: tb/tb_grf_wb.sv
// Self-checking bench for grf_wb: directed cases plus random traffic against an array model.
module tb_grf_wb;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  a1, a2, a3;
   logic [31:0] wd, pc;
   logic [31:0] rd1, rd2;
   logic        trace_valid;
   logic [4:0]  trace_addr;
   logic [31:0] trace_data;
   logic [31:0] trace_pc;
   logic [15:0] wr_count;

   int n_checks = 0;
   int n_fail   = 0;

   bit [31:0] m_regs [32];
   bit        m_tv;
   bit [4:0]  m_ta;
   bit [31:0] m_td, m_tp;
   bit [15:0] m_cnt;

   always #5 clk = ~clk;

   grf_wb dut (
      .clk         (clk),
      .reset       (reset),
      .we          (we),
      .a1          (a1),
      .a2          (a2),
      .a3          (a3),
      .wd          (wd),
      .pc          (pc),
      .rd1         (rd1),
      .rd2         (rd2),
      .trace_valid (trace_valid),
      .trace_addr  (trace_addr),
      .trace_data  (trace_data),
      .trace_pc    (trace_pc),
      .wr_count    (wr_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      foreach (m_regs[i]) m_regs[i] = '0;
      m_tv  = 1'b0;
      m_ta  = '0;
      m_td  = '0;
      m_tp  = '0;
      m_cnt = '0;
   endtask

   function automatic bit [31:0] exp_rd(input bit [4:0] ra, input bit w, input bit [4:0] wa,
                                        input bit [31:0] d);
      if (ra == 0) return 32'd0;
      if (w && wa != 0 && wa == ra) return d;
      return m_regs[ra];
   endfunction

   // One clock: drive, check reads before the edge, update model, check trace after the edge.
   task automatic cycle(input bit w, input bit [4:0] ra1, input bit [4:0] ra2,
                        input bit [4:0] wa, input bit [31:0] d, input bit [31:0] p);
      we = w; a1 = ra1; a2 = ra2; a3 = wa; wd = d; pc = p;
      @(negedge clk);
      chk("rd1", rd1, exp_rd(ra1, w, wa, d));
      chk("rd2", rd2, exp_rd(ra2, w, wa, d));
      @(posedge clk);
      if (w && wa != 0) begin
         m_regs[wa] = d;
         m_tv = 1'b1;
         m_ta = wa;
         m_td = d;
         m_tp = p;
         m_cnt = m_cnt + 16'd1;
      end else begin
         m_tv = 1'b0;
      end
      #1;
      chk("trace_valid", trace_valid, m_tv);
      chk("trace_addr",  trace_addr,  m_ta);
      chk("trace_data",  trace_data,  m_td);
      chk("trace_pc",    trace_pc,    m_tp);
      chk("wr_count",    wr_count,    m_cnt);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      we = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tv_low;
      bit [4:0] wa;
      bit [31:0] d;

      reset = 1'b0; we = 1'b0; a1 = 5'd5; a2 = 5'd31; a3 = '0; wd = '0; pc = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_low_rd1", rd1, 32'd0);
      chk("rst_low_rd2", rd2, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_rd1", rd1, 32'd0);
      chk("post_rst_rd2", rd2, 32'd0);
      chk("post_rst_tv",  trace_valid, 1'b0);
      chk("post_rst_cnt", wr_count, 16'd0);

      // Basic commit and read-back.
      cycle(1'b1, 5'd0, 5'd0, 5'd8, 32'h1234_5678, 32'h0000_3000);
      chk("wr8_trace_addr", trace_addr, 5'd8);
      chk("wr8_trace_pc",   trace_pc, 32'h0000_3000);
      cycle(1'b0, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0);
      chk("rd8_value", rd1, 32'h1234_5678);

      // Write to $0 is discarded.
      cycle(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
      chk("wr0_tv",  trace_valid, 1'b0);
      chk("wr0_cnt", wr_count, 16'd1);
      cycle(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);

      // Same-cycle bypass on both ports, then stored value.
      cycle(1'b1, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, 32'h0000_3008);
      cycle(1'b0, 5'd9, 5'd8, 5'd0, 32'd0, 32'd0);
      chk("reg9_stored", rd1, 32'hDEAD_BEEF);

      // Back-to-back commits.
      cycle(1'b1, 5'd1, 5'd2, 5'd1, 32'hA5A5_0001, 32'h100);
      cycle(1'b1, 5'd1, 5'd2, 5'd2, 32'hA5A5_0002, 32'h104);
      cycle(1'b1, 5'd1, 5'd2, 5'd31, 32'hA5A5_0031, 32'h108);

      // Random traffic with frequent read/write address collisions.
      for (int i = 0; i < 300; i++) begin
         wa = 5'($urandom_range(0, 31));
         cycle(($urandom % 4) != 0,
               ($urandom % 4 == 0) ? wa : 5'($urandom_range(0, 31)),
               ($urandom % 4 == 0) ? wa : 5'($urandom_range(0, 31)),
               wa, $urandom, $urandom);
      end

      // Asynchronous reset mid-cycle.
      cycle(1'b1, 5'd0, 5'd0, 5'd3, 32'h0000_0055, 32'h200);
      we = 1'b1; a1 = 5'd3; a2 = 5'd0; a3 = 5'd4; wd = 32'h0000_0077; pc = 32'h204;
      #2;
      chk("pre_async_rd1", rd1, 32'h0000_0055);
      reset = 1'b0;
      #1;
      model_clear();
      chk("async_rd1",   rd1, 32'd0);
      chk("async_tv",    trace_valid, 1'b0);
      chk("async_taddr", trace_addr, 5'd0);
      chk("async_tdata", trace_data, 32'd0);
      chk("async_tpc",   trace_pc, 32'd0);
      chk("async_cnt",   wr_count, 16'd0);
      @(posedge clk);
      @(negedge clk);
      we = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b0, 5'd3, 5'd4, 5'd0, 32'd0, 32'd0);

      // Counter wrap: 65535 commits then one more.
      do_reset();
      tv_low = 0;
      for (int i = 0; i < 65535; i++) begin
         wa = 5'($urandom_range(1, 31));
         d  = $urandom;
         we = 1'b1; a3 = wa; wd = d; pc = 32'(i);
         @(posedge clk);
         #1;
         m_regs[wa] = d;
         m_cnt = m_cnt + 16'd1;
         if (trace_valid !== 1'b1) tv_low++;
      end
      chk("wrap_cnt_ffff", wr_count, m_cnt);
      chk("wrap_cnt_ffff_abs", wr_count, 16'hFFFF);
      we = 1'b1; a3 = 5'd7; wd = 32'h0BAD_F00D; pc = 32'h0000_FFFF;
      @(posedge clk);
      #1;
      m_cnt = m_cnt + 16'd1;
      if (trace_valid !== 1'b1) tv_low++;
      chk("wrap_cnt_zero", wr_count, 16'h0000);
      chk("wrap_tv_low_cycles", 64'(tv_low), 64'd0);
      chk("wrap_tdata", trace_data, 32'h0BAD_F00D);
      we = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/grf_wb.md
Name: grf_wb

Overview:
- General register file; the receiving end of the write-register-address select path.
- The 5-bit write address chosen upstream (rd/rt/$31) arrives on `a3`. This block commits write-back data into the selected register.
- Provides two read ports with same-cycle write bypass, and emits a registered write-back trace record for the test harness.
- Sits between the write-back select stage and the ALU/compare operand inputs of the datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (must equal 2**ADDR_W).
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  write enable for the current cycle.
- a1  input  ADDR_W  read port 1 address (rs).
- a2  input  ADDR_W  read port 2 address (rt).
- a3  input  ADDR_W  write address from the upstream write-register select.
- wd  input  DATA_W  write data.
- pc  input  32  PC of the instruction performing the write (trace only).
- rd1  output  DATA_W  read data, port 1.
- rd2  output  DATA_W  read data, port 2.
- trace_valid  output  1  pulses one cycle after each committed write.
- trace_addr  output  ADDR_W  register written.
- trace_data  output  DATA_W  value written.
- trace_pc  output  32  PC of the writing instruction.
- wr_count  output  CNT_W  number of committed writes since reset.

Behaviour:
- Reset (reset==0, asynchronous):
  - All NUM_REGS registers clear to 0.
  - trace_valid=0; trace_addr, trace_data, trace_pc = 0; wr_count=0.
  - rd1 and rd2 are forced to 0 while reset is low.
  - Deassertion is sampled at the next rising edge of clk.
- Commit condition: commit = we && (a3 != 0).
  - On a rising edge with commit, reg[a3] <= wd.
  - A write to $0 is discarded. $0 always reads 0.
- Reads are combinational, zero latency.
  - rd1 = 0 if a1==0.
  - Otherwise rd1 = wd if commit && a3==a1 (write-through bypass).
  - Otherwise rd1 = reg[a1].
  - rd2 is identical with a2.
- Simultaneous events:
  - a1==a2==a3 with commit: both ports return wd in the same cycle.
  - The new value is stored at the edge.
- Trace record, updated at each rising edge:
  - trace_valid <= commit.
  - When commit: trace_addr <= a3, trace_data <= wd, trace_pc <= pc.
  - When not commit: trace_addr, trace_data and trace_pc hold their previous values.
  - Latency from commit edge to trace_valid high is 1 cycle.
  - Back-to-back commits give trace_valid high on consecutive cycles with no bubble.
- wr_count increments by 1 on each commit edge.
  - It wraps modulo 2**CNT_W: 0xFFFF + 1 -> 0x0000.
  - A write with we=1, a3=0 does not count.
- Reset mid-operation: a commit in the same cycle that reset falls is lost. Registers, trace and count all read 0.
- No X propagation: every output is driven in every cycle.

Decomposition:
- Shared package (used by the select mux, controller and grf_wb):
  - REG_ZERO=5'd0, REG_RA=5'd31.
  - ADDR_W and DATA_W constants.
  - The write-select encoding used upstream: 0=rt, 1=rd, 2=$31.
- One sub-module is natural: grf_trace, containing the trace register and wr_count.
- The storage array and bypass read logic stay in grf_wb.

Test Plan:
- Reset low then high; read a1=5, a2=31 -> rd1=0, rd2=0, trace_valid=0, wr_count=0.
- we=1, a3=8, wd=0x1234_5678, pc=0x0000_3000; next cycle a1=8 -> rd1=0x12345678. trace_valid=1 with trace_addr=8, trace_data=0x12345678, trace_pc=0x3000. wr_count=1.
- we=1, a3=0, wd=0xFFFF_FFFF; a1=0 -> rd1=0 before and after the edge, trace_valid stays 0, wr_count unchanged.
- we=1, a3=a1=a2=9, wd=0xDEAD_BEEF in the same cycle -> rd1=rd2=0xDEADBEEF combinationally before the edge. reg9 holds 0xDEADBEEF after the edge.
- Force 65535 commits, then 1 more -> wr_count 0xFFFF then 0x0000. trace_valid high on every one of those cycles.
- Write 0x55 to $3, then pulse reset low mid-cycle (not at an edge) -> rd1 (a1=3) drops to 0 immediately, trace outputs and wr_count are 0.
